// File: rtl/hr_dpwm_ctrl.sv
// Sequencing controller for a hybrid counter/delay-line DPWM: splits each duty
// command into a coarse cycle count and a fine delay-line tap, double-buffered per period.
module hr_dpwm_ctrl #(
    parameter int Nde = 64,
    parameter int Nf  = 6,
    parameter int Nc  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [Nc+Nf-1:0]   duty_in,
    input  logic               duty_valid,
    output logic               duty_ready,
    output logic [Nf-1:0]      tap_sel,
    output logic               fine_arm,
    output logic               pwm_set,
    output logic [Nc-1:0]      cnt,
    output logic               period_start,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [Nc-1:0] CNT_MAX  = {Nc{1'b1}};
    localparam logic [Nf-1:0] TAP_MASK = Nf'(Nde - 1);

    state_t             state_q, state_d;
    logic [Nc-1:0]      cnt_q, cnt_d;
    logic [Nc+Nf-1:0]   shadow_q, shadow_d;
    logic               pending_q, pending_d;
    logic [Nc+Nf-1:0]   active_q, active_d;
    logic [Nf-1:0]      tap_sel_q, tap_sel_d;
    logic               fine_arm_q, fine_arm_d;
    logic               pwm_set_q, pwm_set_d;
    logic               period_start_q, period_start_d;

    logic               accept;
    logic               running_d;

    // Strobes are registered, so they are derived from the next-cycle state,
    // counter and (post-transfer) active duty.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        active_d  = active_q;
        accept    = duty_valid && !pending_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) state_d = RUN;
            end
            RUN, STOP: begin
                cnt_d = cnt_q + Nc'(1);
                if (en)                    state_d = RUN;
                else if (cnt_q == CNT_MAX) state_d = IDLE;
                else                       state_d = STOP;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        running_d      = (state_d != IDLE);
        period_start_d = running_d && (cnt_d == '0);

        if (period_start_d && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        // An accept alongside a transfer only happens with pending clear,
        // so it always lands in the shadow for the following period.
        if (accept) begin
            shadow_d  = duty_in;
            pending_d = 1'b1;
        end

        pwm_set_d  = period_start_d && (active_d != '0);
        fine_arm_d = running_d && (active_d != '0) && (cnt_d == active_d[Nc+Nf-1:Nf]);
        tap_sel_d  = active_d[Nf-1:0] & TAP_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            shadow_q       <= '0;
            pending_q      <= 1'b0;
            active_q       <= '0;
            tap_sel_q      <= '0;
            fine_arm_q     <= 1'b0;
            pwm_set_q      <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            active_q       <= active_d;
            tap_sel_q      <= tap_sel_d;
            fine_arm_q     <= fine_arm_d;
            pwm_set_q      <= pwm_set_d;
            period_start_q <= period_start_d;
        end
    end

    assign duty_ready   = !pending_q;
    assign tap_sel      = tap_sel_q;
    assign fine_arm     = fine_arm_q;
    assign pwm_set      = pwm_set_q;
    assign cnt          = cnt_q;
    assign period_start = period_start_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_hr_dpwm_ctrl.sv
// Bench for hr_dpwm_ctrl: a cycle model pushes expected outputs per drive,
// popped and compared after each edge, plus directed checks from the test plan.
module tb_hr_dpwm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [9:0] duty_in = '0;
    logic       duty_valid = 1'b0;
    logic       duty_ready;
    logic [5:0] tap_sel;
    logic       fine_arm;
    logic       pwm_set;
    logic [3:0] cnt;
    logic       period_start;
    logic       busy;

    hr_dpwm_ctrl #(.Nde(64), .Nf(6), .Nc(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .tap_sel      (tap_sel),
        .fine_arm     (fine_arm),
        .pwm_set      (pwm_set),
        .cnt          (cnt),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] tap;
        logic       arm;
        logic       set;
        logic [3:0] cnt;
        logic       ps;
        logic       busy;
        logic       ready;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // model state: 0 idle, 1 run, 2 stop
    int         m_state = 0;
    logic [3:0] m_cnt = '0;
    logic       m_pend = 1'b0;
    logic [9:0] m_shadow = '0;
    logic [9:0] m_active = '0;

    task automatic check(input string tag, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic model(input logic r, input logic e, input logic v, input logic [9:0] d);
        exp_t x;
        int   ns;
        logic [3:0] nc;
        logic run, start, acc;
        if (r) begin
            m_state = 0; m_cnt = '0; m_pend = 1'b0; m_shadow = '0; m_active = '0;
            x = '{tap: 6'd0, arm: 1'b0, set: 1'b0, cnt: 4'd0, ps: 1'b0, busy: 1'b0, ready: 1'b1};
        end else begin
            acc = v && !m_pend;
            if (m_state == 0) begin
                nc = 4'd0;
                ns = e ? 1 : 0;
            end else begin
                nc = m_cnt + 4'd1;
                ns = e ? 1 : ((m_cnt == 4'd15) ? 0 : 2);
            end
            run   = (ns != 0);
            start = run && (nc == 4'd0);
            if (start && m_pend) begin
                m_active = m_shadow;
                m_pend   = 1'b0;
            end
            if (acc) begin
                m_shadow = d;
                m_pend   = 1'b1;
            end
            m_state = ns;
            m_cnt   = nc;
            x.tap   = m_active[5:0];
            x.arm   = run && (m_active != 0) && (nc == m_active[9:6]);
            x.set   = start && (m_active != 0);
            x.cnt   = nc;
            x.ps    = start;
            x.busy  = run;
            x.ready = !m_pend;
        end
        exp_q.push_back(x);
    endtask

    task automatic step(input logic r, input logic e, input logic v, input logic [9:0] d);
        exp_t x;
        rst = r; en = e; duty_valid = v; duty_in = d;
        model(r, e, v, d);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            x = exp_q.pop_front();
            check("tap_sel", tap_sel, x.tap);
            check("fine_arm", fine_arm, x.arm);
            check("pwm_set", pwm_set, x.set);
            check("cnt", cnt, x.cnt);
            check("period_start", period_start, x.ps);
            check("busy", busy, x.busy);
            check("duty_ready", duty_ready, x.ready);
        end
    endtask

    task automatic run_to_cnt(input logic [3:0] t, input logic e);
        for (int i = 0; i < 40; i++) begin
            if (m_state != 0 && m_cnt == t) return;
            step(1'b0, e, 1'b0, 10'h0);
        end
        check("run_to_cnt_timeout", 0, 1);
    endtask

    int arms, sets, starts;

    initial begin
        step(1'b1, 1'b0, 1'b0, 10'h0);
        step(1'b1, 1'b0, 1'b0, 10'h0);
        check("rst_ready", duty_ready, 1);
        check("rst_busy", busy, 0);

        // coarse 10, fine 37
        step(1'b0, 1'b0, 1'b1, 10'h2A5);
        check("s1_pending", duty_ready, 0);
        step(1'b0, 1'b1, 1'b0, 10'h0);
        check("s1_cnt0", cnt, 0);
        check("s1_set", pwm_set, 1);
        check("s1_tap", tap_sel, 37);
        arms = 0;
        for (int i = 0; i < 31; i++) begin
            step(1'b0, 1'b1, 1'b0, 10'h0);
            if (fine_arm) begin
                arms++;
                check("s1_arm_cnt", cnt, 10);
            end
        end
        check("s1_arms", arms, 2);

        // mid-period update, second valid while pending is dropped
        run_to_cnt(4'd5, 1'b1);
        step(1'b0, 1'b1, 1'b1, 10'h040);
        check("s2_ready_low", duty_ready, 0);
        step(1'b0, 1'b1, 1'b1, 10'h3FF);
        run_to_cnt(4'd0, 1'b1);
        check("s2_tap", tap_sel, 0);
        check("s2_ready_high", duty_ready, 1);
        step(1'b0, 1'b1, 1'b0, 10'h0);
        check("s2_arm", fine_arm, 1);
        check("s2_arm_cnt", cnt, 1);
        run_to_cnt(4'd0, 1'b1);
        check("s2_ignored_tap", tap_sel, 0);

        // zero duty
        step(1'b0, 1'b1, 1'b1, 10'h000);
        arms = 0; sets = 0; starts = 0;
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 10'h0);
            arms += int'(fine_arm);
            sets += int'(pwm_set);
            starts += int'(period_start);
        end
        check("s3_starts", starts, 2);
        check("s3_sets", sets, 0);
        check("s3_arms", arms, 0);

        // coarse 0 fine 15, then all-ones
        step(1'b0, 1'b1, 1'b1, 10'h00F);
        run_to_cnt(4'd0, 1'b1);
        check("s4_set", pwm_set, 1);
        check("s4_arm", fine_arm, 1);
        check("s4_tap", tap_sel, 15);
        step(1'b0, 1'b1, 1'b1, 10'h3FF);
        run_to_cnt(4'd0, 1'b1);
        check("s4_max_tap", tap_sel, 63);
        run_to_cnt(4'd15, 1'b1);
        check("s4_max_arm", fine_arm, 1);

        // en drop at 5, re-raise at 9
        run_to_cnt(4'd5, 1'b1);
        step(1'b0, 1'b0, 1'b0, 10'h0);
        check("s5_stop_busy", busy, 1);
        run_to_cnt(4'd9, 1'b0);
        step(1'b0, 1'b1, 1'b0, 10'h0);
        check("s5_nogap_cnt", cnt, 10);
        run_to_cnt(4'd5, 1'b1);
        arms = 0;
        for (int i = 0; i < 20 && m_state != 0; i++) begin
            step(1'b0, 1'b0, 1'b0, 10'h0);
            arms += int'(fine_arm);
        end
        check("s5_stop_arms", arms, 1);
        check("s5_idle_busy", busy, 0);
        check("s5_idle_cnt", cnt, 0);

        // reset mid-period with a pending shadow
        step(1'b0, 1'b1, 1'b0, 10'h0);
        run_to_cnt(4'd3, 1'b1);
        step(1'b0, 1'b1, 1'b1, 10'h155);
        run_to_cnt(4'd7, 1'b1);
        check("s6_pending", duty_ready, 0);
        step(1'b1, 1'b1, 1'b0, 10'h0);
        check("s6_cnt", cnt, 0);
        check("s6_busy", busy, 0);
        check("s6_ready", duty_ready, 1);
        check("s6_strobes", {pwm_set, fine_arm, period_start}, 0);
        check("s6_tap", tap_sel, 0);
        sets = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, 1'b0, 10'h0);
            sets += int'(pwm_set) + int'(fine_arm);
        end
        check("s6_shadow_dropped", sets, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hr_dpwm_ctrl.md
# hr_dpwm_ctrl

Sequencing controller for the high-resolution DPWM. Splits each duty command into a coarse part, timed by a clock-cycle period counter, and a fine part, which selects a delay-line tap. Each period it issues the set pulse, then the fine-arm strobe and tap index, to the output stage (tap mux plus SR latch). The delay line spans exactly one clock period (Nde taps × tpd = Tclk), so the tap index is a sub-cycle delay.

## Interface
- Nde, 64: delay-line tap count; must be a power of 2.
- Nf, 6: fine bits; must equal log2(Nde).
- Nc, 4: coarse bits; switching period = 2^Nc clock cycles.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run request; level-sensitive.
- duty_in  in  Nc+Nf  duty command; [Nc+Nf-1:Nf] is coarse, [Nf-1:0] is fine.
- duty_valid  in  1  duty_in valid.
- duty_ready  out  1  shadow register free; a transfer occurs when valid && ready.
- tap_sel  out  Nf  delay-line tap index for the fine reset; registered.
- fine_arm  out  1  one-cycle strobe that arms the output reset through tap tap_sel.
- pwm_set  out  1  one-cycle strobe that sets the PWM output at period start.
- cnt  out  Nc  period counter value.
- period_start  out  1  one-cycle strobe in the cycle where cnt==0 while running.
- busy  out  1  state != IDLE.

## Operation
- Registers:
  - state ∈ {IDLE, RUN, STOP}
  - cnt[Nc-1:0]
  - shadow[Nc+Nf-1:0] and pending
  - active[Nc+Nf-1:0], split into a_c (coarse) and a_f (fine)
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, shadow=0, pending=0, active=0.
  - tap_sel=0, fine_arm=0, pwm_set=0, period_start=0.
  - duty_ready = ~pending, so it reads 1 from the first cycle after reset.
  - Reset mid-period aborts immediately. No further strobes are issued, and the shadow value is discarded.
- Handshake:
  - An accept loads shadow and sets pending.
  - While pending=1, duty_ready=0.
  - pending clears only on the period-start transfer.
- Period-start transfer happens in any running cycle with cnt==0:
  - If pending, active<=shadow and pending<=0.
  - An accept in that same cycle (possible only when pending=0) loads shadow and is used next period, not this one.
  - The strobes in the cnt==0 cycle use the active value after the transfer.
- IDLE:
  - cnt held at 0; all strobes 0.
  - en=1 moves to RUN at the next edge. The first RUN cycle has cnt==0.
- RUN:
  - cnt increments by 1 each cycle, wrapping from 2^Nc-1 to 0.
  - At cnt==0: period_start=1; pwm_set=1 if active!=0.
  - When cnt==a_c and active!=0: fine_arm=1.
  - tap_sel changes only at period-start transfers and otherwise holds a_f.
  - en=0 moves to STOP at the next edge.
- STOP:
  - Completes the current period with identical strobe behaviour.
  - At the edge leaving cnt==2^Nc-1, moves to IDLE and cnt=0.
  - If en returns to 1 in STOP, the state goes back to RUN with no gap.
  - No transfer happens in STOP, because cnt==0 does not recur there.
- Boundary cases:
  - active==0: no pwm_set and no fine_arm; output stays low all period.
  - a_c==0 and a_f!=0: pwm_set and fine_arm in the same cycle (cnt==0).
  - All-ones duty: fine_arm at cnt==2^Nc-1 with tap_sel=Nde-1, i.e. maximum on-time one tap short of the full period.
  - duty_valid with duty_ready=0: ignored, no overwrite. The requester holds the command.

## Timing
- Each strobe is a registered output, high for exactly one cycle.
- Latency from accept to use: the accepted value becomes active at the first running cnt==0 cycle after the accept edge. That is at most 2^Nc cycles while running; in IDLE it is the first RUN cycle.
- On-time = a_c·Tclk + a_f·(Tclk/Nde).
- duty_ready is combinational from pending and has no path from duty_valid.
- From en rising in IDLE to the first pwm_set is 1 cycle, provided active!=0.

## Test plan
- Reset, then duty_in=0x2A5 (coarse 10, fine 37) with valid, then en=1 → accepted. In the first RUN cycle: cnt=0, pwm_set=1, tap_sel=37. fine_arm at cnt=10. Both repeat every 16 cycles.
- Send 0x040 (coarse 1, fine 0) mid-period → duty_ready=0 until the next cnt==0. Then tap_sel=0 and fine_arm at cnt=1. A second valid while pending is ignored.
- Duty 0x000 → period_start still pulses every 16 cycles. pwm_set and fine_arm stay 0.
- Duty 0x00F (coarse 0, fine 15) → pwm_set and fine_arm both 1 at cnt=0, tap_sel=15. Duty 0x3FF → fine_arm at cnt=15, tap_sel=63.
- Drop en at cnt=5 → busy stays 1, strobes continue through cnt=15, then IDLE with cnt=0. Re-raising en at cnt=9 continues with no gap.
- Assert rst at cnt=7 with pending=1 → next cycle: all outputs 0, cnt=0, duty_ready=1, busy=0. The shadow value is never applied.
